// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUOp/funk codes, function-select enum and FSM state encoding for alu_seq_ctrl
package alu_pkg;

    // Operation class from main control
    localparam logic [2:0] ALUOP_RTYPE = 3'd0;
    localparam logic [2:0] ALUOP_SHIFT = 3'd1;
    localparam logic [2:0] ALUOP_ADD   = 3'd2;
    localparam logic [2:0] ALUOP_SUB   = 3'd3;
    localparam logic [2:0] ALUOP_AND   = 3'd4;
    localparam logic [2:0] ALUOP_OR    = 3'd5;
    localparam logic [2:0] ALUOP_SLT   = 3'd6;
    localparam logic [2:0] ALUOP_MUL   = 3'd7;

    // Function field when ALUOp selects the register-register class
    localparam logic [2:0] FUNK_ADD  = 3'd0;
    localparam logic [2:0] FUNK_SUB  = 3'd1;
    localparam logic [2:0] FUNK_AND  = 3'd2;
    localparam logic [2:0] FUNK_OR   = 3'd3;
    localparam logic [2:0] FUNK_XOR  = 3'd4;
    localparam logic [2:0] FUNK_NOR  = 3'd5;
    localparam logic [2:0] FUNK_SLT  = 3'd6;
    localparam logic [2:0] FUNK_SLTU = 3'd7;

    // Function field when ALUOp selects the shift class
    localparam logic [2:0] FUNK_SLL  = 3'd4;
    localparam logic [2:0] FUNK_SRL  = 3'd5;
    localparam logic [2:0] FUNK_SRA  = 3'd6;

    // Internal function select produced by the decoder
    typedef enum logic [3:0] {
        FN_ADD,
        FN_SUB,
        FN_AND,
        FN_OR,
        FN_XOR,
        FN_NOR,
        FN_SLT,
        FN_SLTU,
        FN_SLL,
        FN_SRL,
        FN_SRA,
        FN_MUL
    } func_sel_e;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_MUL   = 2'd2;

    function automatic logic is_shift_fn(input func_sel_e f);
        return (f == FN_SLL) || (f == FN_SRL) || (f == FN_SRA);
    endfunction

endpackage

// File: rtl/alu_func_decode.sv
// rtl/alu_func_decode.sv - ALUOp/funk to function select; ALU_SEQ_MUL_EN enables the mul decode
module alu_func_decode
    import alu_pkg::*;
(
    input  logic [2:0] alu_op_i,
    input  logic [2:0] funk_i,
    output func_sel_e  fsel_o
);

    // Pure combinational decode; anything unlisted falls back to add
    always_comb begin
        fsel_o = FN_ADD;
        case (alu_op_i)
            ALUOP_RTYPE: begin
                case (funk_i)
                    FUNK_ADD:  fsel_o = FN_ADD;
                    FUNK_SUB:  fsel_o = FN_SUB;
                    FUNK_AND:  fsel_o = FN_AND;
                    FUNK_OR:   fsel_o = FN_OR;
                    FUNK_XOR:  fsel_o = FN_XOR;
                    FUNK_NOR:  fsel_o = FN_NOR;
                    FUNK_SLT:  fsel_o = FN_SLT;
                    default:   fsel_o = FN_SLTU;
                endcase
            end
            ALUOP_SHIFT: begin
                case (funk_i)
                    FUNK_SLL: fsel_o = FN_SLL;
                    FUNK_SRL: fsel_o = FN_SRL;
                    FUNK_SRA: fsel_o = FN_SRA;
                    default:  fsel_o = FN_ADD;
                endcase
            end
            ALUOP_ADD: fsel_o = FN_ADD;
            ALUOP_SUB: fsel_o = FN_SUB;
            ALUOP_AND: fsel_o = FN_AND;
            ALUOP_OR:  fsel_o = FN_OR;
            ALUOP_SLT: fsel_o = FN_SLT;
`ifdef ALU_SEQ_MUL_EN
            ALUOP_MUL: fsel_o = FN_MUL;
`else
            ALUOP_MUL: fsel_o = FN_ADD;
`endif
            default:   fsel_o = FN_ADD;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequenced ALU: single-cycle ops, bit-serial shifts, optional shift-add mul (ALU_SEQ_MUL_EN)
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALUOp,
    input  logic [2:0]       funk,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
`endif

    func_sel_e        fsel;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] shifted;

    logic [1:0]       state_q,  state_d;
    logic [SHW:0]     count_q,  count_d;
    logic [WIDTH-1:0] work_q,   work_d;
    func_sel_e        kind_q,   kind_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q,   done_d;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mplr_q,   mplr_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] acc_next;
`endif

    alu_func_decode u_decode (
        .alu_op_i (ALUOp),
        .funk_i   (funk),
        .fsel_o   (fsel)
    );

    assign shamt = b[SHW-1:0];

    // Single-cycle result; a shift by zero simply passes a through
    always_comb begin
        alu_res = a + b;
        case (fsel)
            FN_SUB:  alu_res = a - b;
            FN_AND:  alu_res = a & b;
            FN_OR:   alu_res = a | b;
            FN_XOR:  alu_res = a ^ b;
            FN_NOR:  alu_res = ~(a | b);
            FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            FN_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            FN_SLL, FN_SRL, FN_SRA: alu_res = a;
            default: alu_res = a + b;
        endcase
    end

    // One-bit shift step of the captured operand
    always_comb begin
        case (kind_q)
            FN_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
            FN_SRL:  shifted = {1'b0, work_q[WIDTH-1:1]};
            default: shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // Accumulator after adding the current multiplicand when the multiplier LSB is set
    always_comb begin
        acc_next = mplr_q[0] ? (acc_q + work_q) : acc_q;
    end
`endif

    // Sequencer next state: accept in IDLE only, iterate, finish with a done pulse
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        work_d   = work_q;
        kind_d   = kind_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mplr_d   = mplr_q;
        acc_d    = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_shift_fn(fsel) && (shamt != '0)) begin
                        state_d = ST_SHIFT;
                        count_d = {1'b0, shamt};
                        work_d  = a;
                        kind_d  = fsel;
`ifdef ALU_SEQ_MUL_EN
                    end else if (fsel == FN_MUL) begin
                        state_d = ST_MUL;
                        count_d = CNT_MUL;
                        work_d  = a;
                        mplr_d  = b;
                        acc_d   = '0;
`endif
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    count_d  = '0;
                    state_d  = ST_IDLE;
                    result_d = shifted;
                    done_d   = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                acc_d  = acc_next;
                work_d = {work_q[WIDTH-2:0], 1'b0};
                mplr_d = {1'b0, mplr_q[WIDTH-1:1]};
                if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    count_d  = '0;
                    state_d  = ST_IDLE;
                    result_d = acc_next;
                    done_d   = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            work_q   <= '0;
            kind_q   <= FN_SLL;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mplr_q   <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            work_q   <= work_d;
            kind_q   <= kind_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef ALU_SEQ_MUL_EN
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl (WIDTH=32), honours ALU_SEQ_MUL_EN
module tb_alu_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   ALUOp = '0;
    logic [2:0]   funk = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ALUOp  (ALUOp),
        .funk   (funk),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    // Reference: what the op computes, from the operation table
    function automatic logic [W-1:0] model_res(input logic [2:0] op, input logic [2:0] f,
                                               input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        logic [W-1:0] r;
        n = int'(y[4:0]);
        r = x + y;
        if (op == 3'd0) begin
            case (f)
                3'd0: r = x + y;
                3'd1: r = x - y;
                3'd2: r = x & y;
                3'd3: r = x | y;
                3'd4: r = x ^ y;
                3'd5: r = ~(x | y);
                3'd6: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                default: r = (x < y) ? 32'd1 : 32'd0;
            endcase
        end else if (op == 3'd1) begin
            if (f == 3'd4)      r = x << n;
            else if (f == 3'd5) r = x >> n;
            else if (f == 3'd6) r = $signed(x) >>> n;
            else                r = x + y;
        end else begin
            case (op)
                3'd2: r = x + y;
                3'd3: r = x - y;
                3'd4: r = x & y;
                3'd5: r = x | y;
                3'd6: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
`ifdef ALU_SEQ_MUL_EN
                default: r = x * y;
`else
                default: r = x + y;
`endif
            endcase
        end
        return r;
    endfunction

    // Reference: cycles from the accepting edge until done is seen
    function automatic int model_lat(input logic [2:0] op, input logic [2:0] f, input logic [W-1:0] y);
        if (op == 3'd1 && (f == 3'd4 || f == 3'd5 || f == 3'd6))
            return int'(y[4:0]) + 1;
`ifdef ALU_SEQ_MUL_EN
        if (op == 3'd7)
            return W + 1;
`endif
        return 1;
    endfunction

    task automatic scramble();
        a     = $urandom;
        b     = $urandom;
        ALUOp = 3'($urandom);
        funk  = 3'($urandom);
    endtask

    task automatic launch(input logic [2:0] op, input logic [2:0] f,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        ALUOp = op; funk = f; a = x; b = y; start = 1'b1;
    endtask

    // Drops start after the accepting edge, garbles operands, waits (bounded) for done
    task automatic wait_done(output logic [W-1:0] res, output int lat, output int bcnt);
        bcnt = 0;
        @(negedge clk);
        start = 1'b0;
        scramble();
        lat = 1;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(negedge clk);
            scramble();
            lat++;
        end
        if (!done) lat = -1;
        res = result;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h zero=%b, want 0 0 0 1", busy, done, result, zero);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b done=%b zero=%b, want 0 0 1", busy, done, zero);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] res;
        int lat, bc;
        // sub 5-7
        launch(3'd0, 3'd1, 32'd5, 32'd7);
        wait_done(res, lat, bc);
        checks++;
        if (res !== 32'hFFFFFFFE || lat !== 1 || bc !== 0) begin
            errors++;
            $display("FAIL sub_5_7: got res=%h lat=%0d busy=%0d, want fffffffe 1 0", res, lat, bc);
        end
        // sra by 4
        launch(3'd1, 3'd6, 32'h80000000, 32'd4);
        wait_done(res, lat, bc);
        checks++;
        if (res !== 32'hF8000000 || lat !== 5 || bc !== 4) begin
            errors++;
            $display("FAIL sra_4: got res=%h lat=%0d busy=%0d, want f8000000 5 4", res, lat, bc);
        end
        // sll by zero
        launch(3'd1, 3'd4, 32'h1234ABCD, 32'hFFFFFFE0);
        wait_done(res, lat, bc);
        checks++;
        if (res !== 32'h1234ABCD || lat !== 1 || bc !== 0) begin
            errors++;
            $display("FAIL sll_0: got res=%h lat=%0d busy=%0d, want 1234abcd 1 0", res, lat, bc);
        end
        // zero flag on a zero result
        launch(3'd3, 3'd0, 32'h5A5A5A5A, 32'h5A5A5A5A);
        wait_done(res, lat, bc);
        checks++;
        if (zero !== 1'b1 || res !== '0) begin
            errors++;
            $display("FAIL zero_flag: got zero=%b res=%h, want 1 0", zero, res);
        end
        // mul (or add without the multiplier)
        launch(3'd7, 3'd0, 32'h00010001, 32'h00010001);
        wait_done(res, lat, bc);
        checks++;
`ifdef ALU_SEQ_MUL_EN
        if (res !== 32'h00020001 || lat !== 33 || bc !== 32) begin
            errors++;
            $display("FAIL mul_op: got res=%h lat=%0d busy=%0d, want 00020001 33 32", res, lat, bc);
        end
`else
        if (res !== 32'h00020002 || lat !== 1 || bc !== 0) begin
            errors++;
            $display("FAIL mul_op: got res=%h lat=%0d busy=%0d, want 00020002 1 0", res, lat, bc);
        end
`endif
    endtask

    task automatic test_ignore_busy_start();
        int k;
        logic [W-1:0] held;
        launch(3'd1, 3'd4, 32'h00000003, 32'd31);
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            start = (k == 3);
            if (k == 3) begin
                ALUOp = 3'd2; funk = 3'd0; a = 32'd7; b = 32'd9;
            end
            if (done) break;
        end
        start = 1'b0;
        checks++;
        if (k !== 32 || result !== 32'h80000000) begin
            errors++;
            $display("FAIL sll_31_ignore: got lat=%0d res=%h, want 32 80000000", k, result);
        end
        held = result;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== held) begin
                errors++;
                $display("FAIL no_queued_start: got done=%b busy=%b res=%h, want 0 0 %h", done, busy, result, held);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [W-1:0] res;
        int lat, bc;
        logic [W-1:0] x, y;
        launch(3'd2, 3'd0, 32'd1, 32'd1);
        wait_done(res, lat, bc);
        launch(3'd1, 3'd6, 32'h80000000, 32'd8);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_shift: got busy=%b done=%b res=%h zero=%b, want 0 0 0 1", busy, done, result, zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset: got done=%b busy=%b, want 0 0", done, busy);
            end
        end
        x = $urandom; y = $urandom;
        launch(3'd0, 3'd0, x, y);
        wait_done(res, lat, bc);
        checks++;
        if (res !== x + y || lat !== 1) begin
            errors++;
            $display("FAIL add_after_reset: got res=%h lat=%0d, want %h 1", res, lat, x + y);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res, x, y;
        int lat, bc;
        launch(3'd1, 3'd5, 32'hF0000000, 32'd3);
        wait_done(res, lat, bc);
        checks++;
        if (res !== 32'h1E000000 || lat !== 4) begin
            errors++;
            $display("FAIL b2b_first: got res=%h lat=%0d, want 1e000000 4", res, lat);
        end
        // start in the done cycle: another shift
        x = $urandom; y = 32'd2;
        ALUOp = 3'd1; funk = 3'd4; a = x; b = y; start = 1'b1;
        wait_done(res, lat, bc);
        checks++;
        if (res !== (x << 2) || lat !== 3 || bc !== 2) begin
            errors++;
            $display("FAIL b2b_shift: got res=%h lat=%0d busy=%0d, want %h 3 2", res, lat, bc, x << 2);
        end
        // start in that done cycle: a single-cycle xor
        x = $urandom; y = $urandom;
        ALUOp = 3'd0; funk = 3'd4; a = x; b = y; start = 1'b1;
        wait_done(res, lat, bc);
        checks++;
        if (res !== (x ^ y) || lat !== 1) begin
            errors++;
            $display("FAIL b2b_xor: got res=%h lat=%0d, want %h 1", res, lat, x ^ y);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] res, x, y, exp;
        logic [2:0] op, f;
        int lat, bc, elat;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            f  = 3'($urandom);
            x  = $urandom;
            y  = $urandom;
            if (($urandom & 1) == 1) x = x | 32'h80000000;
            if (($urandom & 3) == 0) y = x;
            exp  = model_res(op, f, x, y);
            elat = model_lat(op, f, y);
            launch(op, f, x, y);
            wait_done(res, lat, bc);
            checks++;
            if (res !== exp || lat !== elat || bc !== elat - 1 || zero !== (exp == '0)) begin
                errors++;
                $display("FAIL random_op[%0d] op=%0d f=%0d a=%h b=%h: got res=%h lat=%0d busy=%0d zero=%b, want %h %0d %0d %b",
                         i, op, f, x, y, res, lat, bc, zero, exp, elat, elat - 1, (exp == '0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_busy_start();
        test_reset_mid_shift();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
